// File: rtl/iter_st_lanes.sv
// iter_st_lanes
//   Multi-lane iterated-state accumulator. Each of LANES independent WIDTH-bit
//   lanes is advanced once per accepted beat by a mode-selected step function
//   (XOR / ADD / SUB / LOAD). Beats are grouped into frames of DEPTH beats; the
//   last beat of a frame raises out_last and every lane reloads to INIT. The
//   post-step lane values appear one cycle after the beat.
//
// Ports
//   clk       : clock, rising-edge active
//   rst       : asynchronous active-high reset
//   in_valid  : beat present this cycle
//   in_data   : lane i at bits [i*WIDTH +: WIDTH]
//   mode      : 0 XOR, 1 ADD, 2 SUB, 3 LOAD (sampled per beat)
//   clear     : synchronous frame abort; wins over in_valid, beat is dropped
//   out_valid : out_data / out_ovf carry a new result this cycle
//   out_data  : post-step state of each lane
//   out_ovf   : sticky per-lane carry/borrow within the current frame
//   out_last  : asserted with the output of the final beat of a frame
module iter_st_lanes #(
  parameter int              WIDTH = 8,
  parameter int              LANES = 2,
  parameter int              DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [1:0]             mode,
  input  logic                   clear,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_ovf,
  output logic                   out_last
);

  localparam int            CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  // Returns {carry_or_borrow, next_state} for one lane.
  function automatic logic [WIDTH:0] step_f(input logic [1:0]       m,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    case (m)
      2'd0:    r = {1'b0, a ^ b};
      2'd1:    r = {1'b0, a} + {1'b0, b};
      // Widened subtraction: the top bit is set exactly when a < b.
      2'd2:    r = {1'b0, a} - {1'b0, b};
      2'd3:    r = {1'b0, b};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]       acc_r [LANES];
  logic [CW-1:0]          cnt_r;
  logic [LANES-1:0]       ovf_r;

  logic [WIDTH:0]         step_s;
  logic [LANES*WIDTH-1:0] next_s;
  logic [LANES-1:0]       carry_s;
  logic [LANES-1:0]       ovf_base_s;
  logic [LANES-1:0]       ovf_next_s;
  logic                   last_s;

  // Per-lane step evaluation on the current state and incoming beat.
  always_comb begin
    step_s  = '0;
    next_s  = '0;
    carry_s = '0;
    for (int i = 0; i < LANES; i++) begin
      step_s                     = step_f(mode, acc_r[i], in_data[i*WIDTH +: WIDTH]);
      next_s[i*WIDTH +: WIDTH]   = step_s[WIDTH-1:0];
      carry_s[i]                 = step_s[WIDTH];
    end
  end

  // Frame position and sticky overflow; the first beat of a frame starts clean.
  always_comb begin
    ovf_base_s = '0;
    if (cnt_r == '0) begin
      ovf_base_s = '0;
    end else begin
      ovf_base_s = ovf_r;
    end
    ovf_next_s = ovf_base_s | carry_s;
    last_s     = (cnt_r == LAST_CNT);
  end

  // Lane state: reload on reset/clear/frame end, otherwise take the step result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) acc_r[i] <= INIT;
    end else if (clear) begin
      for (int i = 0; i < LANES; i++) acc_r[i] <= INIT;
    end else if (in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (last_s) begin
          acc_r[i] <= INIT;
        end else begin
          acc_r[i] <= next_s[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      for (int i = 0; i < LANES; i++) acc_r[i] <= acc_r[i];
    end
  end

  // Beat counter and frame-local overflow tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      ovf_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
      ovf_r <= '0;
    end else if (in_valid) begin
      ovf_r <= ovf_next_s;
      if (last_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
      ovf_r <= ovf_r;
    end
  end

  // Registered outputs; data and overflow hold while no new beat is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_ovf   <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_last  <= last_s;
      out_data  <= next_s;
      out_ovf   <= ovf_next_s;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
